// File: rtl/arb_req_stage_pkg.sv
// Shared defaults and width helpers for the arbiter request-staging front end.
package arb_pkg;

    localparam int unsigned ARB_N_DEFAULT      = 4;
    localparam int unsigned ARB_DATA_W_DEFAULT = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_req_stage_if.sv
// Request, arbiter and downstream handshake bundle for arb_req_stage.
interface arb_req_stage_if
    import arb_pkg::*;
#(
    parameter int unsigned N      = ARB_N_DEFAULT,
    parameter int unsigned DATA_W = ARB_DATA_W_DEFAULT,
    parameter int unsigned ID_W   = id_width(N)
);

    logic [N-1:0]        req_valid_i;
    logic [N*DATA_W-1:0] req_data_i;
    logic [N-1:0]        req_ready_o;
    logic [N-1:0]        arb_req_o;
    logic [N-1:0]        arb_gnt_i;
    logic                out_valid_o;
    logic [DATA_W-1:0]   out_data_o;
    logic [ID_W-1:0]     out_id_o;
    logic                out_ready_i;
    logic                err_o;

    modport slave (
        input  req_valid_i, req_data_i, arb_gnt_i, out_ready_i,
        output req_ready_o, arb_req_o, out_valid_o, out_data_o, out_id_o, err_o
    );

    modport master (
        output req_valid_i, req_data_i, arb_gnt_i, out_ready_i,
        input  req_ready_o, arb_req_o, out_valid_o, out_data_o, out_id_o, err_o
    );

endinterface

// File: rtl/arb_req_stage_onehot_enc.sv
// Lowest-set-bit encoder with any/multi-hot flags for grant vectors.
module onehot_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    vec_i,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o,
    output logic            multi_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i] && !found) begin
                idx_o = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/arb_req_stage.sv
// Per-requester one-entry staging slots feeding an external arbiter, with a
// registered single-beat output and a sticky grant-protocol error flag.
module arb_req_stage
    import arb_pkg::*;
#(
    parameter int unsigned N      = ARB_N_DEFAULT,
    parameter int unsigned DATA_W = ARB_DATA_W_DEFAULT,
    parameter int unsigned ID_W   = id_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    arb_req_stage_if.slave bus
);

    typedef logic [N-1:0] req_vec_t;

    typedef struct packed {
        logic              full;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t             slot_q [N];
    slot_t             slot_d [N];
    req_vec_t          ready_q, ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              err_q, err_d;

    req_vec_t          slot_full;
    req_vec_t          arb_req;
    req_vec_t          gnt;
    req_vec_t          stray_gnt;
    logic              out_can_take;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              gnt_multi;

    always_comb begin
        slot_full = '0;
        for (int unsigned i = 0; i < N; i++) begin
            slot_full[i] = slot_q[i].full;
        end
    end

    assign out_can_take = ~out_valid_q | bus.out_ready_i;
    assign arb_req      = slot_full & {N{out_can_take}};
    assign gnt          = bus.arb_gnt_i & arb_req;
    assign stray_gnt    = bus.arb_gnt_i & ~arb_req;

    onehot_enc #(
        .N    (N),
        .ID_W (ID_W)
    ) u_gnt_enc (
        .vec_i   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any),
        .multi_o (gnt_multi)
    );

    always_comb begin
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ready_d     = '0;

        // ready_q mirrors ~full, so a slot is never captured and drained together.
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.req_valid_i[i] && ready_q[i]) begin
                slot_d[i].full = 1'b1;
                slot_d[i].data = bus.req_data_i[i*DATA_W +: DATA_W];
            end
        end

        if (gnt_any) begin
            out_valid_d            = 1'b1;
            out_data_d             = slot_q[gnt_idx].data;
            out_id_d               = gnt_idx;
            slot_d[gnt_idx].full   = 1'b0;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        for (int unsigned i = 0; i < N; i++) begin
            ready_d[i] = ~slot_d[i].full;
        end

        err_d = err_q | gnt_multi | (|stray_gnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
            ready_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.arb_req_o   = arb_req;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_id_o    = out_id_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_arb_req_stage.sv
// Scoreboard bench for arb_req_stage with a behavioural fixed-priority arbiter.
module tb_arb_req_stage;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 2;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk;
    logic rst_n;
    logic force_en;
    logic [N-1:0] force_val;

    beat_t sb [$];
    int n_cmp;
    int n_bad;

    arb_req_stage_if #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    arb_req_stage #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority arbiter (lowest index wins) unless a grant is forced.
    always_comb begin
        if (force_en) bus.arb_gnt_i = force_val;
        else          bus.arb_gnt_i = bus.arb_req_o & (~bus.arb_req_o + 4'd1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int slot, input logic [DATA_W-1:0] d);
        bus.req_data_i[slot*DATA_W +: DATA_W] = d;
    endtask

    task automatic push(input int id, input logic [DATA_W-1:0] d);
        beat_t b;
        b.id   = ID_W'(id);
        b.data = d;
        sb.push_back(b);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("sb_id",   bus.out_id_o,   e.id);
                chk("sb_data", bus.out_data_o, e.data);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] cdata [4];
        cdata[0] = 8'h11; cdata[1] = 8'h22; cdata[2] = 8'h33; cdata[3] = 8'h44;
        n_cmp = 0;
        n_bad = 0;
        force_en = 1'b0;
        force_val = '0;
        rst_n = 1'b0;
        bus.req_valid_i = 4'hF;
        bus.req_data_i  = '0;
        bus.out_ready_i = 1'b1;

        // Reset held with requests asserted
        repeat (3) tick();
        chk("rst_ready", bus.req_ready_o, 4'h0);
        chk("rst_valid", bus.out_valid_o, 1'b0);
        chk("rst_err",   bus.err_o,       1'b0);
        chk("rst_areq",  bus.arb_req_o,   4'h0);
        bus.req_valid_i = '0;
        rst_n = 1'b1;
        tick();
        chk("rel_ready", bus.req_ready_o, 4'hF);

        // Single request from requester 2
        bus.req_valid_i = 4'b0100;
        set_data(2, 8'hA5);
        push(2, 8'hA5);
        tick();
        bus.req_valid_i = '0;
        chk("single_areq",  bus.arb_req_o,   4'b0100);
        chk("single_rdy0",  bus.req_ready_o, 4'b1011);
        tick();
        chk("single_valid", bus.out_valid_o, 1'b1);
        chk("single_data",  bus.out_data_o,  8'hA5);
        chk("single_id",    bus.out_id_o,    2);
        chk("single_rdy1",  bus.req_ready_o, 4'hF);
        tick();
        chk("single_idle",  bus.out_valid_o, 1'b0);

        // Contention: all four in the same cycle
        bus.req_valid_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            set_data(i, cdata[i]);
            push(i, cdata[i]);
        end
        tick();
        bus.req_valid_i = '0;
        chk("cont_areq", bus.arb_req_o, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_valid", bus.out_valid_o, 1'b1);
            chk("cont_id",    bus.out_id_o,    i);
            chk("cont_data",  bus.out_data_o,  cdata[i]);
        end
        tick();
        chk("cont_idle", bus.out_valid_o, 1'b0);

        // Back-pressure with two slots loaded
        bus.req_valid_i = 4'b0011;
        set_data(0, 8'hA1);
        set_data(1, 8'hB2);
        push(0, 8'hA1);
        push(1, 8'hB2);
        tick();
        bus.req_valid_i = '0;
        bus.out_ready_i = 1'b0;
        tick();
        chk("bp_first_valid", bus.out_valid_o, 1'b1);
        chk("bp_first_id",    bus.out_id_o,    0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", bus.out_valid_o, 1'b1);
            chk("bp_data",  bus.out_data_o,  8'hA1);
            chk("bp_areq",  bus.arb_req_o,   4'h0);
            chk("bp_ready", bus.req_ready_o, 4'b1101);
        end
        bus.out_ready_i = 1'b1;
        tick();
        chk("bp_next_valid", bus.out_valid_o, 1'b1);
        chk("bp_next_id",    bus.out_id_o,    1);
        chk("bp_next_data",  bus.out_data_o,  8'hB2);
        tick();
        chk("bp_idle", bus.out_valid_o, 1'b0);
        chk("bp_err",  bus.err_o,       1'b0);

        // Multi-hot grant over slots 1 and 2
        bus.req_valid_i = 4'b0110;
        set_data(1, 8'hC1);
        set_data(2, 8'hC2);
        push(1, 8'hC1);
        push(2, 8'hC2);
        tick();
        bus.req_valid_i = '0;
        force_en  = 1'b1;
        force_val = 4'b0110;
        chk("bad_areq", bus.arb_req_o, 4'b0110);
        tick();
        force_en = 1'b0;
        chk("bad_id",    bus.out_id_o,    1);
        chk("bad_data",  bus.out_data_o,  8'hC1);
        chk("bad_err",   bus.err_o,       1'b1);
        chk("bad_keep",  bus.req_ready_o, 4'b1011);
        chk("bad_areq2", bus.arb_req_o,   4'b0100);
        tick();
        chk("bad_id2",  bus.out_id_o,  2);
        chk("bad_sticky", bus.err_o,   1'b1);
        tick();
        chk("bad_idle",   bus.out_valid_o, 1'b0);
        chk("bad_sticky2", bus.err_o,      1'b1);

        // Reset in the middle of traffic
        bus.out_ready_i = 1'b0;
        bus.req_valid_i = 4'hF;
        for (int i = 0; i < 4; i++) set_data(i, 8'hD0 + 8'(i));
        tick();
        bus.req_valid_i = '0;
        tick();
        chk("mid_valid", bus.out_valid_o, 1'b1);
        chk("mid_ready", bus.req_ready_o, 4'b0001);
        rst_n = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid_o, 1'b0);
        chk("mid_rst_areq",  bus.arb_req_o,   4'h0);
        chk("mid_rst_ready", bus.req_ready_o, 4'h0);
        chk("mid_rst_err",   bus.err_o,       1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", bus.req_ready_o, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", bus.out_valid_o, 1'b0);
            chk("mid_no_areq",  bus.arb_req_o,   4'h0);
        end

        // Grant on an empty slot
        force_en  = 1'b1;
        force_val = 4'b1000;
        tick();
        force_en = 1'b0;
        chk("empty_err",   bus.err_o,       1'b1);
        chk("empty_valid", bus.out_valid_o, 1'b0);
        tick();
        chk("empty_sticky", bus.err_o, 1'b1);

        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
